// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package arb_pkg;

  // Arbiter FSM: waiting for a request, or locked onto one requester's packet.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Widest requester vector the helpers accept; index width covers it.
  localparam int unsigned MAX_REQ   = 64;
  localparam int unsigned MAX_IDX_W = 6;

  // Seed for the round-robin pointer; shifted to bit N_REQ-1 so that the
  // first search after reset wraps round to requester 0.
  localparam logic [MAX_REQ-1:0] RST_PTR_SEED = {{(MAX_REQ-1){1'b0}}, 1'b1};

  // Binary index of the set bit in a one-hot vector (0 for an all-zero vector).
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = {MAX_IDX_W{1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | (oh[i] ? MAX_IDX_W'(i) : {MAX_IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_grant.sv
// Combinational round-robin grant: first valid requester strictly after the
// pointer, wrapping round to the lowest index.
module rr_stream_arbiter_grant
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 8
) (
  input  logic [N_REQ-1:0] input_valid,
  input  logic [N_REQ-1:0] current_ready,
  input  logic [N_REQ-1:0] last_ready,
  output logic [N_REQ-1:0] next_ready
);

  localparam int unsigned SEL_W = $clog2(N_REQ);

  logic [MAX_IDX_W-1:0] ptr_s;
  logic                 unused_last_ready_s;

  // last_ready is part of the block's historical interface but not needed here.
  assign unused_last_ready_s = ^last_ready;

  // Search the requesters in rotating order starting just after the pointer.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    next_ready = {N_REQ{1'b0}};
    found      = 1'b0;
    idx        = {SEL_W{1'b0}};
    ptr_s      = onehot_to_idx(MAX_REQ'(current_ready));
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = SEL_W'((int'(ptr_s) + k) % int'(N_REQ));
      if (!found && input_valid[idx]) begin
        next_ready[idx] = 1'b1;
        found           = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter: locks one requester per packet and forwards its
// stream to a single sink with no buffering (ready passes straight through).
module rr_stream_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N_REQ  = 8,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned SEL_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          in_valid,
  input  logic [N_REQ-1:0]          in_last,
  input  logic [N_REQ*DATA_W-1:0]   in_data,
  output logic [N_REQ-1:0]          in_ready,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      busy
);

  localparam logic [N_REQ-1:0] RST_PTR = N_REQ'(RST_PTR_SEED << (N_REQ - 1));

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  last_grant_q, last_grant_d;
  logic [N_REQ-1:0]  next_grant_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              active_s;
  logic              handshake_s;

  rr_stream_arbiter_grant #(
    .N_REQ (N_REQ)
  ) u_grant (
    .input_valid   (in_valid),
    .current_ready (last_grant_q),
    .last_ready    (last_grant_q),
    .next_ready    (next_grant_s)
  );

  // AND-OR mux of the granted requester; payload and last are zeroed unless valid.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = {DATA_W{1'b0}};
    for (int i = 0; i < int'(N_REQ); i++) begin
      sel_valid_s = sel_valid_s | (grant_q[i] & in_valid[i]);
      sel_last_s  = sel_last_s | (grant_q[i] & in_valid[i] & in_last[i]);
      sel_data_s  = sel_data_s | ({DATA_W{grant_q[i] & in_valid[i]}} & in_data[i*DATA_W +: DATA_W]);
    end
  end

  // Drive the stream outputs; nothing is offered or accepted while reset is high.
  always_comb begin
    active_s = (state_q == BUSY) && !rst;
    if (active_s) begin
      out_valid = sel_valid_s;
      out_last  = sel_last_s;
      out_data  = sel_data_s;
      in_ready  = grant_q & {N_REQ{out_ready}};
      out_sel   = SEL_W'(onehot_to_idx(MAX_REQ'(grant_q)));
      busy      = 1'b1;
    end else begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = {DATA_W{1'b0}};
      in_ready  = {N_REQ{1'b0}};
      out_sel   = {SEL_W{1'b0}};
      busy      = 1'b0;
    end
    handshake_s = out_valid & out_ready;
  end

  // Next-state logic: grab a requester from IDLE, release it after its last beat.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = next_grant_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (handshake_s && out_last) begin
          last_grant_d = grant_q;
          grant_d      = {N_REQ{1'b0}};
          state_d      = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        grant_d = {N_REQ{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= {N_REQ{1'b0}};
      last_grant_q <= RST_PTR;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Self-checking bench for rr_stream_arbiter (N_REQ=4, DATA_W=8) using a
// packet-level reference model and requester sources that hold until accepted.
module tb_rr_stream_arbiter;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic          out_last;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    out_sel;
  logic          busy;

  rr_stream_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .out_sel(out_sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] dut_vec;
  assign dut_vec = {in_ready, out_valid, out_last, out_data, out_sel, busy};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester sources: queue of {last,data} beats, enable mask, hold flag.
  logic [8:0] src_q [N][$];
  logic [N-1:0] src_en;
  bit   src_hold [N];

  // Reference model: is a packet in progress, who owns it, round-robin pointer.
  bit m_busy;
  int m_lock;
  int m_ptr;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int best = -1;
    for (int i = 0; i < N; i++) if (v[i] && i > ptr && best < 0) best = i;
    for (int i = 0; i < N; i++) if (v[i] && best < 0) best = i;
    return best;
  endfunction

  function automatic logic [16:0] model_expect();
    logic [3:0] rdy; logic ov, ol, b; logic [7:0] od; logic [1:0] os;
    rdy = 4'b0000; ov = 1'b0; ol = 1'b0; od = 8'h00; os = 2'd0; b = 1'b0;
    if (!rst && m_busy) begin
      b  = 1'b1;
      os = 2'(m_lock);
      ov = in_valid[m_lock];
      if (ov) begin
        ol = in_last[m_lock];
        od = in_data[m_lock*DW +: DW];
      end
      rdy[m_lock] = out_ready;
    end
    return {rdy, ov, ol, od, os, b};
  endfunction

  task automatic add_packet(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) src_q[r].push_back({(k == len - 1), 8'(base + 8'(k))});
  endtask

  // Present source beats for this cycle and settle to mid-cycle.
  task automatic drive();
    logic v;
    for (int i = 0; i < N; i++) begin
      v = src_hold[i] || (src_en[i] && src_q[i].size() > 0);
      in_valid[i] = v;
      src_hold[i] = v;
      if (v) {in_last[i], in_data[i*DW +: DW]} = src_q[i][0];
      else   {in_last[i], in_data[i*DW +: DW]} = 9'h000;
    end
    #4;
  endtask

  // Take the rising edge and advance the reference model and sources.
  task automatic commit();
    bit acc;
    bit lst;
    acc = !rst && m_busy && in_valid[m_lock] && out_ready;
    lst = acc && in_last[m_lock];
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = N - 1;
    end else if (!m_busy) begin
      if (|in_valid) begin
        m_lock = pick(in_valid, m_ptr);
        m_busy = 1'b1;
      end
    end else if (acc) begin
      void'(src_q[m_lock].pop_front());
      src_hold[m_lock] = 1'b0;
      if (lst) begin
        m_ptr  = m_lock;
        m_busy = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    src_en = 4'b0000;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      src_hold[i] = 1'b0;
    end
    drive(); commit();
    drive(); commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    rst = 1'b1; out_ready = 1'b1; src_en = 4'b0000;
    for (int i = 0; i < N; i++) begin src_q[i].delete(); src_hold[i] = 1'b0; end
    for (int t = 0; t < 4; t++) begin
      if (t == 2) rst = 1'b0;
      drive();
      exp = model_expect();
      n_checks++;
      if (dut_vec !== exp) begin n_fail++; $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, dut_vec, exp); end
      commit();
    end
    n_checks++;
    if (dut.last_grant_q !== 4'b1000) begin n_fail++; $display("FAIL reset_pointer got=%b exp=1000", dut.last_grant_q); end
    n_checks++;
    if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
  endtask

  task automatic test_single_packet();
    logic [16:0] exp; int first_ov; logic [8:0] beats[$]; int sels_bad;
    do_reset();
    add_packet(2, 3, 8'hA0);
    src_en = 4'b0100; first_ov = -1; sels_bad = 0;
    for (int t = 0; t < 8; t++) begin
      drive();
      exp = model_expect();
      n_checks++;
      if (dut_vec !== exp) begin n_fail++; $display("FAIL single_pkt cyc=%0d got=%h exp=%h", cyc, dut_vec, exp); end
      if (out_valid && first_ov < 0) first_ov = t;
      if (out_valid && out_sel != 2'd2) sels_bad++;
      if (out_valid && out_ready) beats.push_back({out_last, out_data});
      commit();
    end
    n_checks++;
    if (first_ov !== 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=1", first_ov); end
    n_checks++;
    if (beats.size() != 3 || beats[0] !== 9'h0A0 || beats[1] !== 9'h0A1 || beats[2] !== 9'h1A2) begin
      n_fail++; $display("FAIL single_beats got_n=%0d exp=3 beats A0,A1,A2(last)", beats.size());
    end
    n_checks++;
    if (sels_bad != 0) begin n_fail++; $display("FAIL single_sel got_bad=%0d exp=0", sels_bad); end
    n_checks++;
    if (busy !== 1'b0 || dut.last_grant_q !== 4'b0100) begin
      n_fail++; $display("FAIL single_end busy=%b ptr=%b exp busy=0 ptr=0100", busy, dut.last_grant_q);
    end
  endtask

  task automatic test_fairness();
    logic [16:0] exp; int sels[$]; int hs_cyc[$]; int want[6]; bit bad;
    want = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int r = 0; r < N; r++) begin add_packet(r, 1, 8'(8'h10 * r)); add_packet(r, 1, 8'(8'h10 * r + 1)); end
    src_en = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      drive();
      exp = model_expect();
      n_checks++;
      if (dut_vec !== exp) begin n_fail++; $display("FAIL fairness cyc=%0d got=%h exp=%h", cyc, dut_vec, exp); end
      if (out_valid && out_ready) begin sels.push_back(int'(out_sel)); hs_cyc.push_back(t); end
      commit();
    end
    bad = (sels.size() != 6);
    for (int k = 0; k < 6 && !bad; k++) if (sels[k] != want[k]) bad = 1'b1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL fair_order got_n=%0d exp order 0,1,2,3,0,1", sels.size()); end
    bad = (hs_cyc.size() != 6);
    for (int k = 1; k < hs_cyc.size() && !bad; k++) if (hs_cyc[k] - hs_cyc[k-1] != 2) bad = 1'b1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL fair_spacing got_n=%0d exp 2 cycles per packet", hs_cyc.size()); end
  endtask

  task automatic test_lock();
    logic [16:0] exp; int sels[$]; int leak; bit done1;
    do_reset();
    add_packet(1, 4, 8'hE0);
    add_packet(0, 1, 8'hF0);
    src_en = 4'b0010; leak = 0; done1 = 1'b0;
    for (int t = 0; t < 9; t++) begin
      if (t == 2) src_en = 4'b0011;
      drive();
      exp = model_expect();
      n_checks++;
      if (dut_vec !== exp) begin n_fail++; $display("FAIL lock cyc=%0d got=%h exp=%h", cyc, dut_vec, exp); end
      if (!done1 && in_ready[0]) leak++;
      if (out_valid && out_ready) begin
        sels.push_back(int'(out_sel));
        if (out_sel == 2'd1 && out_last) done1 = 1'b1;
      end
      commit();
    end
    n_checks++;
    if (leak != 0) begin n_fail++; $display("FAIL lock_leak got=%0d exp=0", leak); end
    n_checks++;
    if (sels.size() != 5 || sels[3] != 1 || sels[4] != 0) begin
      n_fail++; $display("FAIL lock_next got_n=%0d exp 1,1,1,1,0", sels.size());
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp; logic [8:0] beats[$]; bit rdy_sched[7]; int stall_ok;
    rdy_sched = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    add_packet(2, 2, 8'hB0);
    src_en = 4'b0100; stall_ok = 0;
    for (int t = 0; t < 7; t++) begin
      out_ready = rdy_sched[t];
      drive();
      exp = model_expect();
      n_checks++;
      if (dut_vec !== exp) begin n_fail++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, dut_vec, exp); end
      if (out_valid && out_ready) beats.push_back({out_last, out_data});
      if (!out_ready && out_valid && out_data == 8'hB1 && in_ready == 4'b0000) stall_ok++;
      commit();
    end
    out_ready = 1'b1;
    n_checks++;
    if (beats.size() != 2 || beats[0] !== 9'h0B0 || beats[1] !== 9'h1B1) begin
      n_fail++; $display("FAIL bp_beats got_n=%0d exp 2 beats B0,B1(last)", beats.size());
    end
    n_checks++;
    if (stall_ok != 2) begin n_fail++; $display("FAIL bp_hold got=%0d exp=2", stall_ok); end
  endtask

  task automatic test_valid_gap();
    logic [16:0] exp; int sels[$]; int gap, n3, gap_seen;
    do_reset();
    add_packet(3, 3, 8'hC0);
    add_packet(0, 1, 8'hD0);
    gap = 0; n3 = 0; gap_seen = 0;
    for (int t = 0; t < 10; t++) begin
      src_en[0] = (t >= 1);
      if (gap > 0) begin src_en[3] = 1'b0; gap--; end
      else src_en[3] = 1'b1;
      drive();
      exp = model_expect();
      n_checks++;
      if (dut_vec !== exp) begin n_fail++; $display("FAIL valid_gap cyc=%0d got=%h exp=%h", cyc, dut_vec, exp); end
      if (busy && !out_valid && out_sel == 2'd3 && n3 == 1) gap_seen++;
      if (out_valid && out_ready) begin
        sels.push_back(int'(out_sel));
        if (out_sel == 2'd3) begin n3++; if (n3 == 1) gap = 2; end
      end
      commit();
    end
    n_checks++;
    if (gap_seen != 2) begin n_fail++; $display("FAIL gap_hold got=%0d exp=2", gap_seen); end
    n_checks++;
    if (sels.size() != 4 || sels[0] != 3 || sels[2] != 3 || sels[3] != 0) begin
      n_fail++; $display("FAIL gap_order got_n=%0d exp 3,3,3,0", sels.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] exp; int h1, first_sel; bit post;
    do_reset();
    add_packet(0, 1, 8'h60); add_packet(0, 1, 8'h61);
    add_packet(1, 3, 8'h70);
    add_packet(2, 1, 8'h80); add_packet(3, 1, 8'h90);
    src_en = 4'b1111; h1 = 0; first_sel = -1; post = 1'b0;
    for (int t = 0; t < 10; t++) begin
      rst = (t == 4);
      drive();
      exp = model_expect();
      n_checks++;
      if (dut_vec !== exp) begin n_fail++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, dut_vec, exp); end
      if (t == 5) begin
        n_checks++;
        if (dut_vec !== 17'h0 || dut.state_q !== IDLE) begin
          n_fail++; $display("FAIL rmid_after got=%h state=%0d exp=0 IDLE", dut_vec, dut.state_q);
        end
        post = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (post && first_sel < 0) first_sel = int'(out_sel);
        if (out_sel == 2'd1) h1++;
      end
      commit();
    end
    rst = 1'b0;
    n_checks++;
    if (first_sel != 0) begin n_fail++; $display("FAIL rmid_grant got=%0d exp=0", first_sel); end
  endtask

  task automatic test_random();
    logic [16:0] exp; logic [3:0] ptr_oh;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int r = 0; r < N; r++)
        if (src_q[r].size() == 0) add_packet(r, int'($urandom_range(1, 4)), 8'($urandom));
      for (int r = 0; r < N; r++) src_en[r] = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 75);
      rst = ($urandom_range(0, 199) == 0);
      drive();
      exp = model_expect();
      n_checks++;
      if (dut_vec !== exp) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp); end
      ptr_oh = 4'b0001 << m_ptr;
      n_checks++;
      if (dut.last_grant_q !== ptr_oh) begin n_fail++; $display("FAIL random_ptr cyc=%0d got=%b exp=%b", cyc, dut.last_grant_q, ptr_oh); end
      commit();
    end
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; src_en = 4'b0000;
    in_valid = 4'b0000; in_last = 4'b0000; in_data = 32'h0;
    m_busy = 1'b0; m_lock = 0; m_ptr = N - 1;
    @(posedge clk); #1;
    test_reset();
    test_single_packet();
    test_fairness();
    test_lock();
    test_backpressure();
    test_valid_gap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Round-robin packet arbiter that sits directly downstream of the combinational round-robin grant logic.
- Owns the registered "current/last grant" state that the grant logic consumes, locks the selected requester for a whole packet, and muxes its stream onto one output.
- Used wherever N SIMD lanes or cores share a single stream sink, such as a memory port or result bus.

Parameters:
- N_REQ, 8, number of requesters; must be >= 2.
- DATA_W, 32, payload width per requester.
- SEL_W, $clog2(N_REQ), width of the granted-index output; derived, do not override.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_REQ  per-requester valid.
- in_last  in  N_REQ  per-requester end-of-packet flag, qualified by in_valid.
- in_data  in  N_REQ*DATA_W  payloads, packed; requester i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  N_REQ  per-requester ready; at most one bit set.
- out_valid  out  1  output valid.
- out_last  out  1  output end-of-packet.
- out_data  out  DATA_W  output payload.
- out_ready  in  1  sink ready.
- out_sel  out  SEL_W  binary index of the locked requester; valid while out_valid=1.
- busy  out  1  a packet is in progress (state BUSY).

Behaviour:
- Handshake: a beat transfers when valid and ready are both 1 on a rising clk edge.
- Requesters must hold in_valid/in_data/in_last stable until accepted.
- State machine has two states: IDLE and BUSY.
- Registers:
  - state.
  - grant (one-hot, N_REQ bits).
  - last_grant (one-hot, N_REQ bits); this is the round-robin pointer.
- Reset (rst=1 at a clk edge):
  - state=IDLE, grant=0, last_grant=1<<(N_REQ-1), so requester 0 has top priority first.
  - All outputs 0: in_ready, out_valid, out_last, out_data, out_sel, busy.
  - Reset mid-packet abandons the packet; no beat is accepted in the reset cycle.
- Next-grant rule (combinational, from in_valid and last_grant):
  - Pick the lowest-index valid requester whose index is strictly greater than the index in last_grant.
  - If there is none, pick the lowest-index valid requester overall (wrap-around).
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - If any in_valid=1: grant <= next-grant and state <= BUSY. Arbitration latency is one cycle from valid to first out_valid.
  - Else: remain in IDLE.
- BUSY (g = index of grant):
  - busy=1, out_sel=g.
  - out_valid=in_valid[g], out_data=in_data[g], out_last=in_last[g].
  - in_ready[g]=out_ready; all other in_ready bits are 0.
  - The combinational ready path is out_ready -> in_ready; there is no registering, so the block adds no buffering.
  - If the locked requester deasserts valid between beats: stay in BUSY with the lock held. out_valid=0 and no other requester is served.
  - On a handshake with in_last[g]=1: last_grant <= grant, grant <= 0, state <= IDLE.
  - One idle bubble is required between packets; this is accepted and is the throughput contract.
- Single-beat packets (in_last=1 on the first beat) complete in BUSY in one cycle, given out_ready=1.
- Requests that arrive while BUSY are ignored until IDLE and are never lost, because their valid is held.
- Fairness: with all N_REQ requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0, and no requester waits more than N_REQ-1 packets.
- When out_valid=0, out_data and out_last are 0 (not don't-care), so scoreboards may compare them directly.

Decomposition:
- Shared package arb_pkg holds:
  - typedef state_e {IDLE, BUSY}.
  - function onehot_to_idx(N_REQ one-hot) -> SEL_W.
  - a localparam for the reset pointer value.
- One natural sub-module: the existing combinational round-robin grant block, instantiated with:
  - input_valid = in_valid.
  - current_ready = last_grant.
  - last_ready = last_grant (its last_ready input is unused).
  - Its next_ready output feeds the grant register.
- The output mux is an inline AND-OR over the one-hot grant; no separate module.

Test Plan (N_REQ=4, DATA_W=8):
- Reset, then in_valid=4'b0100 with a 3-beat packet (0xA0,0xA1,0xA2; last on the third beat), out_ready=1.
  - Required: out_valid first rises 1 cycle after valid; out_sel=2; three beats 0xA0..0xA2; busy drops after the last beat; last_grant=4'b0100.
- All four requesters continuously valid with 1-beat packets, out_ready=1.
  - Required: grant order 0,1,2,3,0,1; each packet takes 2 cycles (IDLE + BUSY).
- Requester 1 locked with a 4-beat packet; requester 0 raises valid mid-packet.
  - Required: requester 0 gets no in_ready until requester 1's last beat; requester 0 is granted next.
- Backpressure: out_ready toggles 1,0,0,1 during a 2-beat packet.
  - Required: in_ready[g] mirrors out_ready; no beat is duplicated or dropped; out_data is held while stalled.
- Locked requester 3 drops valid for 2 cycles between beats while requester 0 is valid.
  - Required: busy stays 1, out_valid=0, out_sel=3, no grant change.
- Assert rst during the second beat of a 3-beat packet.
  - Required: the next cycle has all outputs 0 and state IDLE; with all requesters valid, the next grant is requester 0.
